// File: rtl/digital_clk_pkg.sv
// Shared types and defaults for the digital clock family: alarm FSM encoding,
// timer width and the default millisecond timeouts.
package digital_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

    localparam int RING_MS_DEF    = 60000;
    localparam int SNOOZE_MS_DEF  = 300000;
    localparam int MAX_SNOOZE_DEF = 3;

    localparam int TMR_W = 19;

    // Buzzer is on for the first half of every second of the time base
    localparam logic [9:0] BUZZ_ON_MS = 10'd500;

    function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] t);
        return (t == {TMR_W{1'b1}}) ? t : t + 1'b1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level input sampled on clk_i; rise_o is high in
// the cycle where d_i is high and was low on the previous cycle.
module edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic rise_o
);

    logic r_d_prev;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_d_prev <= 1'b0;
        end else begin
            r_d_prev <= d_i;
        end
    end

    assign rise_o = d_i & ~r_d_prev;

endmodule

// File: rtl/alarm_ctrl_24hr.sv
// Alarm sequencer for the 24 h clock: arms, rings at the alarm minute, handles
// snooze/stop buttons, times out unattended rings and flags them as missed.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | alarm disabled (arm_i low)
//   ST_ARMED   | waiting for hh:mm:00.000 to match the alarm time
//   ST_RINGING | buzzer pattern active, ring timer counting
//   ST_SNOOZE  | buzzer silent, snooze timer counting back to ringing
module alarm_ctrl_24hr
    import digital_clk_pkg::*;
#(
    parameter int RING_MS    = RING_MS_DEF,
    parameter int SNOOZE_MS  = SNOOZE_MS_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic [9:0] ms_i,
    input  logic [5:0] alarm_hour_i,
    input  logic [5:0] alarm_min_i,
    input  logic       arm_i,
    input  logic       snooze_i,
    input  logic       stop_i,
    output logic       buzzer_o,
    output logic [1:0] state_o,
    output logic [1:0] snooze_cnt_o,
    output logic       missed_o
);

    localparam logic [TMR_W-1:0] RING_TC   = TMR_W'(RING_MS - 1);
    localparam logic [TMR_W-1:0] SNOOZE_TC = TMR_W'(SNOOZE_MS - 1);
    localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

    alarm_state_t     r_state;
    logic [TMR_W-1:0] r_ring_tmr;
    logic [TMR_W-1:0] r_snz_tmr;
    logic [1:0]       r_snooze_cnt;
    logic             r_missed;
    logic             r_trig_lock;

    logic w_snooze_rise;
    logic w_stop_rise;
    logic w_min_match;
    logic w_trigger_raw;
    logic w_trigger;

    edge_detect u_snooze_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (snooze_i),
        .rise_o  (w_snooze_rise)
    );

    edge_detect u_stop_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (stop_i),
        .rise_o  (w_stop_rise)
    );

    assign w_min_match   = (hour_i == alarm_hour_i) && (min_i == alarm_min_i);
    assign w_trigger_raw = w_min_match && (sec_i == 6'd0) && (ms_i == 10'd0);
    assign w_trigger     = w_trigger_raw && !r_trig_lock;

    // Lock holds off a second trigger until the time leaves the alarm minute,
    // covering a stalled or re-loaded time base.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_trig_lock <= 1'b0;
        end else if (!w_min_match) begin
            r_trig_lock <= 1'b0;
        end else if (w_trigger_raw) begin
            r_trig_lock <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= ST_IDLE;
            r_ring_tmr   <= '0;
            r_snz_tmr    <= '0;
            r_snooze_cnt <= 2'd0;
            r_missed     <= 1'b0;
        end else if (!arm_i) begin
            r_state    <= ST_IDLE;
            r_missed   <= 1'b0;
            r_ring_tmr <= '0;
            r_snz_tmr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                end

                ST_ARMED: begin
                    if (w_stop_rise) begin
                        r_missed <= 1'b0;
                    end
                    if (w_trigger) begin
                        r_state      <= ST_RINGING;
                        r_ring_tmr   <= '0;
                        r_snooze_cnt <= 2'd0;
                    end
                end

                ST_RINGING: begin
                    if (w_stop_rise) begin
                        r_state <= ST_ARMED;
                    end else if (w_snooze_rise && (r_snooze_cnt < SNZ_MAX)) begin
                        r_state      <= ST_SNOOZE;
                        r_snooze_cnt <= r_snooze_cnt + 2'd1;
                        r_snz_tmr    <= '0;
                    end else if (r_ring_tmr == RING_TC) begin
                        r_state  <= ST_ARMED;
                        r_missed <= 1'b1;
                    end else begin
                        r_ring_tmr <= tmr_sat_inc(r_ring_tmr);
                    end
                end

                ST_SNOOZE: begin
                    if (w_stop_rise) begin
                        r_state <= ST_ARMED;
                    end else if (r_snz_tmr == SNOOZE_TC) begin
                        r_state    <= ST_RINGING;
                        r_ring_tmr <= '0;
                    end else begin
                        r_snz_tmr <= tmr_sat_inc(r_snz_tmr);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o      = r_state;
    assign snooze_cnt_o = r_snooze_cnt;
    assign missed_o     = r_missed;

    // Registered state decode gated by the live ms compare so the 1 Hz pattern
    // stays phase-locked to the time base.
    assign buzzer_o = (r_state == ST_RINGING) && (ms_i < BUZZ_ON_MS);

endmodule

// File: tb/tb_alarm_ctrl_24hr.sv
// Directed bench for alarm_ctrl_24hr with shortened ring/snooze timeouts.
module tb_alarm_ctrl_24hr;

    localparam int RING_MS    = 8;
    localparam int SNOOZE_MS  = 12;
    localparam int MAX_SNOOZE = 3;

    logic       clk;
    logic       reset_n;
    logic [5:0] hour, minute, sec;
    logic [9:0] ms;
    logic [5:0] al_hour, al_min;
    logic       arm, snooze, stop;
    logic       buzzer_o;
    logic [1:0] state_o;
    logic [1:0] snooze_cnt_o;
    logic       missed_o;

    int n_vec = 0;
    int n_err = 0;

    alarm_ctrl_24hr #(
        .RING_MS    (RING_MS),
        .SNOOZE_MS  (SNOOZE_MS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_n),
        .hour_i       (hour),
        .min_i        (minute),
        .sec_i        (sec),
        .ms_i         (ms),
        .alarm_hour_i (al_hour),
        .alarm_min_i  (al_min),
        .arm_i        (arm),
        .snooze_i     (snooze),
        .stop_i       (stop),
        .buzzer_o     (buzzer_o),
        .state_o      (state_o),
        .snooze_cnt_o (snooze_cnt_o),
        .missed_o     (missed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input logic [5:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic [9:0] t_ms);
        hour   = h;
        minute = m;
        sec    = s;
        ms     = t_ms;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        arm     = 1'b0;
        snooze  = 1'b0;
        stop    = 1'b0;
        al_hour = 6'd7;
        al_min  = 6'd30;
        set_time(6'd7, 6'd29, 6'd59, 10'd999);

        step(2);
        chk("rst_state",  32'(state_o),      32'd0);
        chk("rst_buzzer", 32'(buzzer_o),     32'd0);
        chk("rst_cnt",    32'(snooze_cnt_o), 32'd0);
        chk("rst_missed", 32'(missed_o),     32'd0);
        reset_n = 1'b1;

        step(1);
        chk("idle_noarm", 32'(state_o), 32'd0);
        arm = 1'b1;
        step(1);
        chk("arm_state", 32'(state_o), 32'd1);
        step(1);
        chk("armed_pre_trig", 32'(state_o), 32'd1);

        // Trigger at 07:30:00.000, buzzer pattern follows ms
        set_time(6'd7, 6'd30, 6'd0, 10'd0);
        step(1);
        chk("trig_ring",  32'(state_o),  32'd2);
        chk("buz_ms0",    32'(buzzer_o), 32'd1);
        ms = 10'd499; #1;
        chk("buz_ms499",  32'(buzzer_o), 32'd1);
        ms = 10'd500; #1;
        chk("buz_ms500",  32'(buzzer_o), 32'd0);
        ms = 10'd999; #1;
        chk("buz_ms999",  32'(buzzer_o), 32'd0);
        ms = 10'd100;

        // First snooze, with a re-press inside SNOOZE that must be ignored
        snooze = 1'b1;
        step(1);
        chk("snz1_state", 32'(state_o),      32'd3);
        chk("snz1_cnt",   32'(snooze_cnt_o), 32'd1);
        chk("snz_buz",    32'(buzzer_o),     32'd0);
        snooze = 1'b0;
        step(1);
        snooze = 1'b1;
        step(1);
        chk("snz_ignore_cnt", 32'(snooze_cnt_o), 32'd1);
        snooze = 1'b0;
        step(9);
        chk("snz1_last", 32'(state_o), 32'd3);
        step(1);
        chk("snz1_back_ring", 32'(state_o), 32'd2);

        snooze = 1'b1;
        step(1);
        chk("snz2_cnt", 32'(snooze_cnt_o), 32'd2);
        snooze = 1'b0;
        step(11);
        chk("snz2_last", 32'(state_o), 32'd3);
        step(1);
        chk("snz2_back_ring", 32'(state_o), 32'd2);

        snooze = 1'b1;
        step(1);
        chk("snz3_cnt", 32'(snooze_cnt_o), 32'd3);
        snooze = 1'b0;
        step(12);
        chk("snz3_back_ring", 32'(state_o), 32'd2);

        // Fourth snooze ignored; ring timer keeps running into timeout
        snooze = 1'b1;
        step(1);
        chk("snz4_state", 32'(state_o),      32'd2);
        chk("snz4_cnt",   32'(snooze_cnt_o), 32'd3);
        snooze = 1'b0;
        step(6);
        chk("ring_last",   32'(state_o),  32'd2);
        chk("ring_missed0", 32'(missed_o), 32'd0);
        step(1);
        chk("timeout_state",  32'(state_o),  32'd1);
        chk("timeout_missed", 32'(missed_o), 32'd1);
        chk("timeout_buz",    32'(buzzer_o), 32'd0);

        stop = 1'b1;
        step(1);
        chk("stop_clr_missed", 32'(missed_o), 32'd0);
        chk("stop_armed",      32'(state_o),  32'd1);
        stop = 1'b0;
        step(1);

        // Same minute again: locked out
        set_time(6'd7, 6'd30, 6'd0, 10'd0);
        step(1);
        chk("lock_same_min", 32'(state_o), 32'd1);
        set_time(6'd7, 6'd31, 6'd0, 10'd0);
        step(1);
        set_time(6'd7, 6'd30, 6'd0, 10'd0);
        step(1);
        chk("retrig_ring", 32'(state_o),      32'd2);
        chk("retrig_cnt0", 32'(snooze_cnt_o), 32'd0);

        // Simultaneous stop and snooze in RINGING
        ms = 10'd5;
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        step(12);
        chk("sim_pre_ring", 32'(state_o), 32'd2);
        snooze = 1'b1;
        stop   = 1'b1;
        step(1);
        chk("sim_state", 32'(state_o),      32'd1);
        chk("sim_cnt",   32'(snooze_cnt_o), 32'd1);
        snooze = 1'b0;
        stop   = 1'b0;

        // arm_i dropped in SNOOZE
        set_time(6'd7, 6'd31, 6'd0, 10'd0);
        step(1);
        set_time(6'd7, 6'd30, 6'd0, 10'd0);
        step(1);
        chk("ring3", 32'(state_o), 32'd2);
        ms = 10'd7;
        snooze = 1'b1;
        step(1);
        chk("ring3_snz", 32'(state_o), 32'd3);
        snooze = 1'b0;
        arm    = 1'b0;
        step(1);
        chk("disarm_idle", 32'(state_o), 32'd0);
        arm = 1'b1;
        step(1);
        chk("rearm", 32'(state_o), 32'd1);
        set_time(6'd7, 6'd30, 6'd0, 10'd0);
        step(1);
        chk("rearm_no_trig", 32'(state_o), 32'd1);
        set_time(6'd7, 6'd30, 6'd59, 10'd999);
        step(1);
        set_time(6'd7, 6'd31, 6'd0, 10'd0);
        step(1);
        chk("rearm_wait", 32'(state_o), 32'd1);
        set_time(6'd7, 6'd30, 6'd0, 10'd0);
        step(1);
        chk("rearm_trig", 32'(state_o), 32'd2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;

        // Hour 24 matches on plain equality
        al_hour = 6'd24;
        al_min  = 6'd0;
        set_time(6'd23, 6'd59, 6'd59, 10'd999);
        step(1);
        set_time(6'd24, 6'd0, 6'd0, 10'd0);
        step(1);
        chk("hour24_trig", 32'(state_o), 32'd2);

        // Reset mid-ring silences the buzzer before the next edge
        ms = 10'd100;
        #1;
        chk("midring_buz", 32'(buzzer_o), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_ring_buz",   32'(buzzer_o), 32'd0);
        chk("rst_ring_state", 32'(state_o),  32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_idle", 32'(state_o), 32'd0);
        step(1);
        chk("rel_armed", 32'(state_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
